led_panel_rx: RTL and testbench
===============================

LED_PANEL_RX -- requirements
Module: led_panel_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning input synchronizer depth (legal values 2..3).
REQ-002 SHALL have port clk  input  1  system clock, at least 4x the led_CLK frequency.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports led_A, led_B, led_C, led_D  input  1 each  row address bits 0..3.
REQ-005 SHALL have port led_DI  input  1  serial column data, active-low (0 = LED on).
REQ-006 SHALL have port led_CLK  input  1  shift clock; data is valid on its rising edge.
REQ-007 SHALL have port led_LAT  input  1  latch; its rising edge commits the row.
REQ-008 SHALL have port led_G  input  1  output-enable/brightness strobe.
REQ-009 SHALL have port row_valid  output  1  one-clk pulse: row committed.
REQ-010 SHALL have port row_addr  output  4  row index of the committed row.
REQ-011 SHALL have port row_data  output  64  committed row pixels, 1 = LED on.
REQ-012 SHALL have port frame_start  output  1  one-clk pulse, coincident with row_valid when row_addr==0.
REQ-013 SHALL have port short_err  output  1  sticky flag: a latch arrived with fewer than 64 bits shifted.
REQ-014 SHALL have port bright_cnt  output  16  clk cycles per frame with led_G high.

Function
REQ-015 All led_* inputs SHALL pass through SYNC_STAGES flip-flops; edges SHALL be detected on the synchronized values.
REQ-016 FSM SHALL have states ALIGN, SHIFT, COMMIT; reset enters ALIGN.
REQ-017 In ALIGN, the first LAT rising edge SHALL transition to SHIFT with bit_cnt=0, and SHALL NOT produce an output.
REQ-018 In SHIFT, each led_CLK rising edge SHALL shift ~led_DI into a 64-bit register, so that the earliest bit since the last latch lands at row_data[0] after 64 shifts, and SHALL increment bit_cnt, saturating at 64.
REQ-019 On a LAT rising edge in SHIFT with bit_cnt==64, the FSM SHALL go to COMMIT.
REQ-020 COMMIT SHALL last one clk: register row_data and row_addr (ABCD sampled at the LAT edge), pulse row_valid, clear bit_cnt, and return to SHIFT.
REQ-021 Latency SHALL be exactly SYNC_STAGES+2 clk from the LAT rising edge at the pin to row_valid high.
REQ-022 On a LAT rising edge with bit_cnt<64, the block SHALL set short_err, SHALL NOT pulse row_valid, and SHALL clear bit_cnt.
REQ-023 More than 64 shifts before a latch SHALL keep the last 64 bits, with no error.
REQ-024 A CLK rising edge and a LAT rising edge in the same clk SHALL shift first, then evaluate the latch using the updated bit_cnt.
REQ-025 row_data and row_addr SHALL hold their values between row_valid pulses.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear row_valid, frame_start, short_err, row_addr, row_data, bit_cnt, bright_cnt and the synchronizers, and SHALL force the FSM to ALIGN, including mid-row.
REQ-027 short_err SHALL clear only on reset.

Configuration
REQ-028 Macro LED_PANEL_RX_BRIGHT_EN defined: an internal 16-bit counter SHALL count clk cycles with synchronized led_G high, saturating at 0xFFFF; on frame_start it SHALL load into bright_cnt and restart at 0.
REQ-029 Macro undefined: bright_cnt SHALL be constant 0 and no counter logic SHALL be built.

Structure
REQ-030 Package led_panel_pkg SHALL hold ROW_BITS=64, ROW_NUM=16, ADDR_W=4 and the FSM state enum.
REQ-031 Sub-module led_in_sync SHALL implement one synchronizer plus rising-edge detector and SHALL be instantiated once per input signal.

Verification
REQ-032 Bench SHALL cover: reset, then one LAT edge, then 64 bits alternating 1,0 (DI values), ABCD=5, then LAT -> row_valid once, row_addr=5, row_data=64'hAAAA_AAAA_AAAA_AAAA.
REQ-033 Bench SHALL cover: 16 rows with addr 0..15 and DI all 0 -> 16 row_valid pulses, row_data all ones, frame_start only with row 0.
REQ-034 Bench SHALL cover: 40 bits then LAT -> short_err=1, no row_valid; next 64-bit row commits normally.
REQ-035 Bench SHALL cover: 70 bits then LAT -> row_data = last 64 bits, short_err unchanged.
REQ-036 Bench SHALL cover: rst_n low after 30 bits -> outputs 0 immediately; a following LAT only realigns, with no row_valid.
REQ-037 Bench SHALL cover, with LED_PANEL_RX_BRIGHT_EN: led_G high 1000 clk per frame -> bright_cnt=1000 at the second frame_start.

Source files
------------

// File: rtl/led_panel_pkg.sv
// Shared constants and FSM state type for the LED panel row receiver.
package led_panel_pkg;
  localparam int ROW_BITS = 64;
  localparam int ROW_NUM  = 16;
  localparam int ADDR_W   = $clog2(ROW_NUM);
  localparam int CNT_W    = $clog2(ROW_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ROW_BITS);

  typedef enum logic [1:0] {
    ST_ALIGN  = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;
endpackage

// File: rtl/led_in_sync.sv
// Multi-stage synchronizer for one asynchronous pin plus a rising-edge strobe
// derived from the synchronized value.
module led_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/led_panel_rx.sv
// Sniffs a HUB-style LED panel bus and reassembles committed 64-pixel rows.
// Optional frame brightness counter enabled by macro LED_PANEL_RX_BRIGHT_EN.
module led_panel_rx
  import led_panel_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_A,
  input  logic                led_B,
  input  logic                led_C,
  input  logic                led_D,
  input  logic                led_DI,
  input  logic                led_CLK,
  input  logic                led_LAT,
  input  logic                led_G,
  output logic                row_valid,
  output logic [ADDR_W-1:0]   row_addr,
  output logic [ROW_BITS-1:0] row_data,
  output logic                frame_start,
  output logic                short_err,
  output logic [15:0]         bright_cnt
);
  // Pin order: 0..3 address, 4 DI, 5 CLK, 6 LAT, 7 G
  logic [7:0] pin_s, sync_s, rise_s;
  assign pin_s = {led_G, led_LAT, led_CLK, led_DI, led_D, led_C, led_B, led_A};

  for (genvar i = 0; i < 8; i++) begin : g_sync
    led_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (pin_s[i]),
      .q    (sync_s[i]),
      .rise (rise_s[i])
    );
  end

  logic              clk_rise_s, lat_rise_s, di_s;
  logic [ADDR_W-1:0] addr_s;
  assign addr_s     = sync_s[3:0];
  assign di_s       = sync_s[4];
  assign clk_rise_s = rise_s[5];
  assign lat_rise_s = rise_s[6];

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, cnt_upd_s;
  logic [ROW_BITS-1:0]   shreg_q, shreg_d, row_data_q, row_data_d;
  logic [ADDR_W-1:0]     addr_pend_q, addr_pend_d, row_addr_q, row_addr_d;
  logic                  row_valid_q, row_valid_d, frame_start_q, frame_start_d;
  logic                  short_err_q, short_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ALIGN;
    else        state_q <= state_d;
  end

  // A shift in the same cycle as the latch is counted before the latch is judged.
  always_comb begin
    if (clk_rise_s && (bit_cnt_q != CNT_FULL)) cnt_upd_s = bit_cnt_q + CNT_W'(1);
    else                                       cnt_upd_s = bit_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ALIGN: begin
        if (lat_rise_s) state_d = ST_SHIFT;
        else            state_d = ST_ALIGN;
      end
      ST_SHIFT: begin
        if (lat_rise_s && (cnt_upd_s == CNT_FULL)) state_d = ST_COMMIT;
        else                                       state_d = ST_SHIFT;
      end
      ST_COMMIT: state_d = ST_SHIFT;
      default:   state_d = ST_ALIGN;
    endcase
  end

  always_comb begin
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    addr_pend_d   = addr_pend_q;
    row_data_d    = row_data_q;
    row_addr_d    = row_addr_q;
    row_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    short_err_d   = short_err_q;
    case (state_q)
      ST_ALIGN: bit_cnt_d = {CNT_W{1'b0}};
      ST_SHIFT: begin
        if (clk_rise_s) shreg_d = {~di_s, shreg_q[ROW_BITS-1:1]};
        else            shreg_d = shreg_q;
        bit_cnt_d = cnt_upd_s;
        if (lat_rise_s) begin
          addr_pend_d = addr_s;
          if (cnt_upd_s != CNT_FULL) begin
            short_err_d = 1'b1;
            bit_cnt_d   = {CNT_W{1'b0}};
          end else begin
            short_err_d = short_err_q;
          end
        end else begin
          addr_pend_d = addr_pend_q;
        end
      end
      ST_COMMIT: begin
        row_valid_d   = 1'b1;
        frame_start_d = (addr_pend_q == {ADDR_W{1'b0}});
        row_data_d    = shreg_q;
        row_addr_d    = addr_pend_q;
        // A shift landing in the commit cycle is the first bit of the next row.
        if (clk_rise_s) shreg_d = {~di_s, shreg_q[ROW_BITS-1:1]};
        else            shreg_d = shreg_q;
        bit_cnt_d = {{(CNT_W-1){1'b0}}, clk_rise_s};
      end
      default: bit_cnt_d = {CNT_W{1'b0}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q       <= {ROW_BITS{1'b0}};
      bit_cnt_q     <= {CNT_W{1'b0}};
      addr_pend_q   <= {ADDR_W{1'b0}};
      row_data_q    <= {ROW_BITS{1'b0}};
      row_addr_q    <= {ADDR_W{1'b0}};
      row_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      short_err_q   <= 1'b0;
    end else begin
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      addr_pend_q   <= addr_pend_d;
      row_data_q    <= row_data_d;
      row_addr_q    <= row_addr_d;
      row_valid_q   <= row_valid_d;
      frame_start_q <= frame_start_d;
      short_err_q   <= short_err_d;
    end
  end

  assign row_valid   = row_valid_q;
  assign row_addr    = row_addr_q;
  assign row_data    = row_data_q;
  assign frame_start = frame_start_q;
  assign short_err   = short_err_q;

`ifdef LED_PANEL_RX_BRIGHT_EN
  logic [15:0] g_cnt_q, g_cnt_d, bright_q, bright_d;
  logic        unused_s;
  assign unused_s = ^{rise_s[7], rise_s[4:0], sync_s[6:5]};

  always_comb begin
    bright_d = bright_q;
    g_cnt_d  = g_cnt_q;
    if (frame_start_d) begin
      bright_d = g_cnt_q;
      g_cnt_d  = 16'd0;
    end else if (sync_s[7] && (g_cnt_q != 16'hFFFF)) begin
      g_cnt_d = g_cnt_q + 16'd1;
    end else begin
      g_cnt_d = g_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_cnt_q  <= 16'd0;
      bright_q <= 16'd0;
    end else begin
      g_cnt_q  <= g_cnt_d;
      bright_q <= bright_d;
    end
  end

  assign bright_cnt = bright_q;
`else
  logic unused_s;
  assign unused_s   = ^{rise_s[7], rise_s[4:0], sync_s[7:5]};
  assign bright_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_led_panel_rx.sv
// Scoreboarded random bench for led_panel_rx; bright_cnt expectations follow LED_PANEL_RX_BRIGHT_EN.
module tb_led_panel_rx;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic led_A = 1'b0, led_B = 1'b0, led_C = 1'b0, led_D = 1'b0;
  logic led_DI = 1'b0, led_CLK = 1'b0, led_LAT = 1'b0, led_G = 1'b0;
  logic        row_valid, frame_start, short_err;
  logic [3:0]  row_addr;
  logic [63:0] row_data;
  logic [15:0] bright_cnt;

  always #5 clk = ~clk;

  led_panel_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n),
    .led_A(led_A), .led_B(led_B), .led_C(led_C), .led_D(led_D),
    .led_DI(led_DI), .led_CLK(led_CLK), .led_LAT(led_LAT), .led_G(led_G),
    .row_valid(row_valid), .row_addr(row_addr), .row_data(row_data),
    .frame_start(frame_start), .short_err(short_err), .bright_cnt(bright_cnt)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
    logic        fs;
    logic [15:0] bright;
    logic        serr;
    int          lat_cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rv_count = 0;

  // Reference model: bits shifted since the last latch, alignment, sticky error, brightness.
  logic        bits_q[$];
  bit          aligned  = 1'b0;
  logic        m_serr   = 1'b0;
  int          g_accum  = 0;
  logic [15:0] m_bright = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      if (frame_start === 1'b1) check("frame_start_with_row_valid", 64'(row_valid), 64'd1);
      if (row_valid === 1'b1) begin
        rv_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_row_valid: got row_valid=1 row_addr=%0d, required no commit", row_addr);
        end else begin
          e = exp_q.pop_front();
          check("row_addr", 64'(row_addr), 64'(e.addr));
          check("row_data", row_data, e.data);
          check("frame_start", 64'(frame_start), 64'(e.fs));
          check("short_err_at_row", 64'(short_err), 64'(e.serr));
          check("bright_cnt", 64'(bright_cnt), 64'(e.bright));
          check("latency", 64'(cyc - e.lat_cyc), 64'(SYNC + 2));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_latch();
    exp_t e;
    logic [3:0] a;
    a = {led_D, led_C, led_B, led_A};
    if (!aligned) begin
      aligned = 1'b1;
    end else if (bits_q.size() >= 64) begin
      for (int i = 0; i < 64; i++) e.data[i] = ~bits_q[bits_q.size() - 64 + i];
      e.addr = a;
      e.fs   = (a == 4'd0);
      if (a == 4'd0) begin
`ifdef LED_PANEL_RX_BRIGHT_EN
        m_bright = (g_accum > 65535) ? 16'hFFFF : 16'(g_accum);
`else
        m_bright = 16'd0;
`endif
        g_accum = 0;
      end
      e.bright  = m_bright;
      e.serr    = m_serr;
      e.lat_cyc = cyc;
      exp_q.push_back(e);
    end else begin
      m_serr = 1'b1;
    end
    bits_q.delete();
  endtask

  task automatic set_addr(input logic [3:0] a);
    {led_D, led_C, led_B, led_A} = a;
  endtask

  // mode 0: DI alternating 1,0; mode 1: DI all 0; mode 2: random
  task automatic send_bits(input int n, input int mode, input bit lat_with_last);
    int hp;
    logic di;
    for (int i = 0; i < n; i++) begin
      hp = $urandom_range(2, 4);
      if (mode == 0)      di = (i % 2 == 0);
      else if (mode == 1) di = 1'b0;
      else                di = 1'($urandom_range(0, 1));
      led_DI = di;
      tick(hp);
      led_CLK = 1'b1;
      bits_q.push_back(di);
      if (lat_with_last && i == n - 1) begin
        led_LAT = 1'b1;
        model_latch();
        tick(3);
        led_LAT = 1'b0;
        led_CLK = 1'b0;
        tick(8);
      end else begin
        tick(hp);
        led_CLK = 1'b0;
      end
    end
  endtask

  task automatic pulse_lat();
    tick(2);
    led_LAT = 1'b1;
    model_latch();
    tick(3);
    led_LAT = 1'b0;
    tick(8);
  endtask

  task automatic g_burst(input int n);
    led_G = 1'b1;
    tick(n);
    led_G = 1'b0;
    g_accum += n;
    tick(4);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_row_valid"}, 64'(row_valid), 64'd0);
    check({tag, "_frame_start"}, 64'(frame_start), 64'd0);
    check({tag, "_short_err"}, 64'(short_err), 64'd0);
    check({tag, "_row_addr"}, 64'(row_addr), 64'd0);
    check({tag, "_row_data"}, row_data, 64'd0);
    check({tag, "_bright_cnt"}, 64'(bright_cnt), 64'd0);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got no end of test, required completion within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int rv_before;
    tick(4);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick(5);

    // First latch only aligns, then an alternating row at address 5
    set_addr(4'd5);
    rv_before = rv_count;
    pulse_lat();
    check("align_no_row_valid", 64'(rv_count), 64'(rv_before));
    send_bits(64, 0, 1'b0);
    pulse_lat();
    tick(4);
    check("alt_row_data_hold", row_data, 64'hAAAA_AAAA_AAAA_AAAA);
    check("alt_row_addr_hold", 64'(row_addr), 64'd5);

    // Random rows, one with CLK and LAT rising together on the last bit
    for (int r = 0; r < 3; r++) begin
      set_addr(4'($urandom_range(1, 15)));
      send_bits(64, 2, 1'b0);
      pulse_lat();
    end
    set_addr(4'($urandom_range(1, 15)));
    send_bits(64, 2, 1'b1);

    // Short row raises the sticky error without a commit
    set_addr(4'd9);
    rv_before = rv_count;
    send_bits(40, 2, 1'b0);
    pulse_lat();
    tick(4);
    check("short_err_set", 64'(short_err), 64'(m_serr));
    check("short_no_row_valid", 64'(rv_count), 64'(rv_before));
    set_addr(4'd10);
    send_bits(64, 2, 1'b0);
    pulse_lat();

    // Over-length row keeps the last 64 bits
    set_addr(4'd11);
    send_bits(70, 2, 1'b0);
    pulse_lat();
    tick(4);
    check("short_err_sticky", 64'(short_err), 64'd1);

    // Reset in the middle of a row
    set_addr(4'd12);
    send_bits(30, 2, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    led_CLK = 1'b0; led_LAT = 1'b0; led_DI = 1'b0;
    #1 check_zero_outputs("midrow_reset");
    aligned = 1'b0; m_serr = 1'b0; g_accum = 0; m_bright = 16'd0;
    bits_q.delete();
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    tick(5);
    rv_before = rv_count;
    send_bits(20, 2, 1'b0);
    pulse_lat();
    tick(4);
    check("realign_no_row_valid", 64'(rv_count), 64'(rv_before));
    set_addr(4'd7);
    send_bits(64, 2, 1'b0);
    pulse_lat();

    // Two full frames of lit rows, with a 1000-cycle G burst in each
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 16; r++) begin
        set_addr(4'(r));
        send_bits(64, 1, 1'b0);
        pulse_lat();
        if (r == 3) g_burst(1000);
      end
    end
    set_addr(4'd0);
    send_bits(64, 1, 1'b0);
    pulse_lat();

    tick(20);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
